// File: rtl/tristate_bus_arbiter_if.sv
// Bus-side signals of the tristate bus arbiter: per-agent requests coming in,
// per-buffer enables and bus status going out.
//
// Handshake: req[i] is a level request that agent i holds for as long as it
// wants the bus; enable[i] high is the grant, and agent i owns the bus on every
// cycle its enable bit is high; the agent releases by dropping req[i], after
// which the bus floats (turn=1) for the turnaround gap before any new grant.
interface tristate_bus_arbiter_if #(
    parameter int N_REQ = 4
) ();
    localparam int OW = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] enable;
    logic [OW-1:0]    owner;
    logic             busy;
    logic             turn;

    // Arbiter side
    modport master (
        input  req,
        output enable,
        output owner,
        output busy,
        output turn
    );

    // Requesting agents / tristate buffers side
    modport slave (
        output req,
        input  enable,
        input  owner,
        input  busy,
        input  turn
    );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter and sequencer for a shared tristate bus. Grants at most
// one buffer enable at a time and floats the bus for TURNAROUND cycles between
// drivers so two buffers never drive together.
// Optional feature: define TRISTATE_BUS_ARB_TIMEOUT_EN to preempt an owner that
// has driven MAX_HOLD cycles while another agent is waiting.
module tristate_bus_arbiter #(
    parameter int N_REQ      = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tristate_bus_arbiter_if.master bus,
    output logic [1:0]            state_dbg
);
    localparam int OW = $clog2(N_REQ);
    localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Reject parameter values outside the supported range at elaboration
    if (N_REQ < 2 || N_REQ > 16 || TURNAROUND < 1 || MAX_HOLD < 1) begin : g_bad_param
        $error("tristate_bus_arbiter: parameter out of range");
    end

    state_t           state;
    logic [N_REQ-1:0] enable_q;
    logic [OW-1:0]    owner_q;
    logic [OW-1:0]    last_owner;
    logic [TW-1:0]    turn_cnt;
    logic             busy_q;
    logic             turn_q;

    logic             any_req;
    logic [OW-1:0]    winner;
    logic [OW-1:0]    cand;
    logic             preempt;

    // Round-robin pick: scan from the farthest offset to the nearest so the
    // first requester above last_owner wins, last_owner itself ranking last
    always_comb begin
        any_req = |bus.req;
        winner  = '0;
        cand    = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = OW'((int'(last_owner) + i) % N_REQ);
            if (bus.req[cand]) begin
                winner = cand;
            end
        end
    end

`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    logic [HW-1:0] hold_cnt;

    // Preempt once the owner has used its hold budget and someone else waits
    always_comb begin
        preempt = (hold_cnt == HW'(MAX_HOLD - 1)) && |(bus.req & ~enable_q);
    end
`else
    // Without the timeout an owner keeps the bus until it drops req
    always_comb begin
        preempt = 1'b0;
    end
`endif

    // Sequencer: IDLE -> DRIVE -> TURN (-> DRIVE | IDLE), all outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            enable_q   <= '0;
            owner_q    <= '0;
            last_owner <= OW'(N_REQ - 1);
            turn_cnt   <= '0;
            busy_q     <= 1'b0;
            turn_q     <= 1'b0;
`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
            hold_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= DRIVE;
                        enable_q   <= ONE << winner;
                        owner_q    <= winner;
                        last_owner <= winner;
                        busy_q     <= 1'b1;
`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
                        hold_cnt   <= '0;
`endif
                    end
                end
                DRIVE: begin
                    // A release at the same edge as a timeout lands in the same TURN
                    if (!bus.req[owner_q] || preempt) begin
                        state    <= TURN;
                        enable_q <= '0;
                        busy_q   <= 1'b0;
                        turn_q   <= 1'b1;
                        turn_cnt <= '0;
                    end
`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
                    else if (hold_cnt != HW'(MAX_HOLD - 1)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                TURN: begin
                    if (turn_cnt == TW'(TURNAROUND - 1)) begin
                        turn_q <= 1'b0;
                        if (any_req) begin
                            state      <= DRIVE;
                            enable_q   <= ONE << winner;
                            owner_q    <= winner;
                            last_owner <= winner;
                            busy_q     <= 1'b1;
`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
                            hold_cnt   <= '0;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    enable_q <= '0;
                    busy_q   <= 1'b0;
                    turn_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.enable = enable_q;
    assign bus.owner  = owner_q;
    assign bus.busy   = busy_q;
    assign bus.turn   = turn_q;
    assign state_dbg  = state;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: two instances (turnaround 1 and 3) share a
// clock and reset. Directed stimulus pushes the expected grant record
// {enable, float cycles before grant, drive cycles} into a queue; a negedge
// monitor pops and compares whenever a grant ends, and checks the bus
// invariants every cycle.
module tb_tristate_bus_arbiter;
    localparam int N = 4;
    localparam int W = N + 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // clock
    always #5 clk = ~clk;

    tristate_bus_arbiter_if #(.N_REQ(N)) bus_a ();
    tristate_bus_arbiter_if #(.N_REQ(N)) bus_b ();
    logic [1:0] st_a;
    logic [1:0] st_b;

    tristate_bus_arbiter #(.N_REQ(N), .TURNAROUND(1), .MAX_HOLD(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .state_dbg(st_a)
    );
    tristate_bus_arbiter #(.N_REQ(N), .TURNAROUND(3), .MAX_HOLD(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .state_dbg(st_b)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_q_b[$];
    logic mon_on = 1'b0;
    logic [N-1:0] prev_en[2];
    int gap[2];
    int cur_gap[2];
    int len[2];

    function automatic string pfx(input int s);
        return (s == 0) ? "a_" : "b_";
    endfunction

    function automatic logic [N-1:0] get_en(input int s);
        return (s == 0) ? bus_a.enable : bus_b.enable;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int s, input logic [N-1:0] v);
        if (s == 0) bus_a.req = v;
        else        bus_b.req = v;
    endtask

    task automatic expect_rec(input int s, input logic [N-1:0] en, input int g, input int l);
        logic [W-1:0] rec;
        rec = {en, 8'(g), 8'(l)};
        if (s == 0) exp_q.push_back(rec);
        else        exp_q_b.push_back(rec);
    endtask

    task automatic wait_grant(input int s, input logic [N-1:0] want);
        int n = 0;
        while ((get_en(s) & want) == '0 && n < 60) begin
            tick(1);
            n++;
        end
        check({pfx(s), "grant"}, get_en(s), want);
    endtask

    // expect a grant, wait for it, hold it `hold` cycles, then present next_req
    task automatic serve(input int s, input logic [N-1:0] want, input int g,
                         input int hold, input logic [N-1:0] next_req);
        expect_rec(s, want, g, hold);
        wait_grant(s, want);
        if (hold > 1) tick(hold - 1);
        set_req(s, next_req);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic mon_step(input int s, input logic [N-1:0] en, input logic [1:0] own,
                            input logic busy, input logic turn);
        logic [W-1:0] got;
        logic [W-1:0] want;
        logic [N-1:0] one;
        one = 1;
        check({pfx(s), "onehot"}, $countones(en) <= 1, 1);
        check({pfx(s), "busy"}, busy, |en);
        check({pfx(s), "en_in_turn"}, turn & (|en), 0);
        if (|en) check({pfx(s), "owner"}, en, one << own);
        if (|en) begin
            if (prev_en[s] == '0) begin
                cur_gap[s] = gap[s];
                gap[s] = 0;
                len[s] = 0;
            end
            len[s]++;
        end else begin
            if (prev_en[s] != '0) begin
                got = {prev_en[s], 8'(cur_gap[s]), 8'(len[s])};
                if ((s == 0 && exp_q.size() == 0) || (s == 1 && exp_q_b.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL %sunexpected_grant: got %0h want none", pfx(s), got);
                end else begin
                    want = (s == 0) ? exp_q.pop_front() : exp_q_b.pop_front();
                    check({pfx(s), "grant_rec"}, got, want);
                end
            end
            if (turn) gap[s]++;
            else      gap[s] = 0;
        end
        prev_en[s] = en;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon_step(0, bus_a.enable, bus_a.owner, bus_a.busy, bus_a.turn);
            mon_step(1, bus_b.enable, bus_b.owner, bus_b.busy, bus_b.turn);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bus_a.req = '0;
        bus_b.req = '0;
        for (int i = 0; i < 2; i++) begin
            prev_en[i] = '0;
            gap[i] = 0;
            cur_gap[i] = 0;
            len[i] = 0;
        end
        rst_n = 1'b0;
        tick(3);
        mon_on = 1'b1;

        // reset state
        check("a_rst_enable", bus_a.enable, 0);
        check("a_rst_busy", bus_a.busy, 0);
        check("a_rst_turn", bus_a.turn, 0);
        check("a_rst_owner", bus_a.owner, 0);
        check("a_rst_state", st_a, 0);
        check("b_rst_enable", bus_b.enable, 0);
        check("b_rst_turn", bus_b.turn, 0);
        check("b_rst_state", st_b, 0);
        rst_n = 1'b1;
        tick(1);

        // req 0101: index 0 first with one-edge latency, then 2 after one float cycle
        set_req(0, 4'b0101);
        tick(1);
        check("a_idle_latency", bus_a.enable, 4'b0001);
        serve(0, 4'b0001, 0, 3, 4'b0100);
        serve(0, 4'b0100, 1, 2, 4'b0000);
        tick(4);

        // turnaround 3: owner 1 releases with req[2] pending
        expect_rec(1, 4'b0010, 0, 2);
        set_req(1, 4'b0010);
        wait_grant(1, 4'b0010);
        set_req(1, 4'b0110);
        tick(1);
        set_req(1, 4'b0100);
        expect_rec(1, 4'b0100, 3, 2);
        tick(1);
        check("b_turn_first", {bus_b.turn, bus_b.enable}, 5'b10000);
        tick(2);
        check("b_turn_last", {bus_b.turn, bus_b.enable}, 5'b10000);
        tick(1);
        check("b_after_turn", {bus_b.turn, bus_b.enable}, 5'b00100);
        tick(1);
        set_req(1, 4'b0000);
        tick(6);

        // round robin 0,1,2,3,0 with all requesting, each holding 2 cycles
        reset_pulse();
        set_req(0, 4'b1111);
        for (int k = 0; k < N; k++) begin
            serve(0, 4'(1 << k), (k == 0) ? 0 : 1, 2, 4'b1111 & ~4'(1 << k));
            tick(1);
            set_req(0, 4'b1111);
        end
        serve(0, 4'b0001, 1, 2, 4'b0000);
        tick(4);

        // hold timeout with req 0011 held
        reset_pulse();
`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
        set_req(0, 4'b0011);
        expect_rec(0, 4'b0001, 0, 4);
        wait_grant(0, 4'b0001);
        expect_rec(0, 4'b0010, 1, 4);
        wait_grant(0, 4'b0010);
        tick(3);
        set_req(0, 4'b0000);
        tick(4);
        // lone owner keeps the bus; preempted at the first edge another req is seen
        set_req(0, 4'b0001);
        expect_rec(0, 4'b0001, 0, 11);
        wait_grant(0, 4'b0001);
        tick(10);
        set_req(0, 4'b0011);
        expect_rec(0, 4'b0010, 1, 1);
        wait_grant(0, 4'b0010);
        set_req(0, 4'b0000);
`else
        set_req(0, 4'b0011);
        expect_rec(0, 4'b0001, 0, 21);
        wait_grant(0, 4'b0001);
        for (int c = 0; c < 20; c++) begin
            tick(1);
            check("a_no_timeout", bus_a.enable, 4'b0001);
        end
        set_req(0, 4'b0000);
`endif
        tick(4);

        // reset while owner 2 drives, then 0110 after release goes to index 1
        set_req(0, 4'b0100);
        expect_rec(0, 4'b0100, 0, 3);
        wait_grant(0, 4'b0100);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check("a_midrst_enable", bus_a.enable, 0);
        check("a_midrst_busy", bus_a.busy, 0);
        check("a_midrst_turn", bus_a.turn, 0);
        check("a_midrst_owner", bus_a.owner, 0);
        set_req(0, 4'b0110);
        rst_n = 1'b1;
        serve(0, 4'b0010, 0, 2, 4'b0000);
        tick(6);

        check("a_queue_empty", exp_q.size(), 0);
        check("b_queue_empty", exp_q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
